// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/single-step sequencer for the Hack core, driven by debounced
// DE0 buttons and a PC breakpoint comparator.  Rev 1.0
`default_nettype none

module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter bit START_RUN         = 1'b0,
  parameter int PC_WIDTH          = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          btn_n,
  input  logic                bp_enable,
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                cpu_en,
  output logic                cpu_reset,
  output logic [2:0]          state,
  output logic                bp_hit,
  output logic [31:0]         instr_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HALT  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic [2:0]      sync1, sync2, db_level, press;
  logic [DB_W-1:0] db_cnt [3];

  // Buttons are asynchronous: invert to active-high, synchronize, then debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      press    <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
      for (int b = 0; b < 3; b++) begin
        press[b] <= 1'b0;
        if (sync2[b] == db_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db_cnt[b]   <= '0;
          db_level[b] <= sync2[b];
          press[b]    <= sync2[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  state_t            st, st_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              skip_bp, skip_n;
  logic              rst_p, run_p, step_p, bp_match;

  always_comb begin
    rst_p     = press[0];
    run_p     = press[1] & ~press[0];
    step_p    = press[2] & ~press[1] & ~press[0];
    bp_match  = bp_enable && (pc == bp_addr) && !skip_bp;
    st_n      = st;
    hold_n    = hold_cnt;
    skip_n    = skip_bp;
    cpu_en    = 1'b0;
    cpu_reset = 1'b0;
    bp_hit    = 1'b0;
    case (st)
      S_RESET: begin
        cpu_en    = 1'b1;
        cpu_reset = 1'b1;
        if (hold_cnt <= HOLD_W'(1)) begin
          st_n   = START_RUN ? S_RUN : S_HALT;
          skip_n = 1'b0;
        end else begin
          hold_n = hold_cnt - HOLD_W'(1);
        end
      end
      S_HALT: begin
        if (run_p) begin
          st_n   = S_RUN;
          skip_n = 1'b0;
        end else if (step_p) begin
          st_n = S_STEP;
        end
      end
      S_RUN: begin
        // Gate the enable combinationally so the breakpoint instruction never executes.
        cpu_en = ~bp_match;
        skip_n = 1'b0;
        if (run_p)         st_n = S_HALT;
        else if (bp_match) st_n = S_BREAK;
      end
      S_STEP: begin
        cpu_en = 1'b1;
        st_n   = S_HALT;
      end
      S_BREAK: begin
        bp_hit = 1'b1;
        if (run_p) begin
          st_n   = S_RUN;
          skip_n = 1'b1;
        end else if (step_p) begin
          st_n = S_STEP;
        end
      end
      default: begin
        st_n   = S_RESET;
        hold_n = HOLD_LOAD;
      end
    endcase
    if (rst_p) begin
      st_n   = S_RESET;
      hold_n = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_RESET;
      hold_cnt    <= HOLD_LOAD;
      skip_bp     <= 1'b0;
      instr_count <= '0;
    end else begin
      st       <= st_n;
      hold_cnt <= hold_n;
      skip_bp  <= skip_n;
      if (st == S_RESET || rst_p)
        instr_count <= '0;
      else if (cpu_en && !cpu_reset && instr_count != 32'hFFFF_FFFF)
        instr_count <= instr_count + 32'd1;
    end
  end

  assign state = st;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scoreboard bench for cpu_run_ctrl with a behavioural model.
`default_nettype none

module tb_cpu_run_ctrl;
  localparam int D  = 4;
  localparam int H  = 4;
  localparam int PW = 15;

  localparam int M_RESET = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3, M_BREAK = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    btn_n = 3'b111;
  logic          bp_enable = 1'b0;
  logic [PW-1:0] bp_addr = '0;
  logic [PW-1:0] pc = '0;
  logic          cpu_en, cpu_reset, bp_hit;
  logic [2:0]    state;
  logic [31:0]   instr_count;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(D), .RESET_HOLD_CYCLES(H), .START_RUN(1'b0), .PC_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en), .cpu_reset(cpu_reset), .state(state), .bp_hit(bp_hit),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        st;
    bit        en;
    bit        rst;
    bit        hit;
    bit [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Next-cycle drive values (active-high button levels).
  bit [2:0]    d_btn = 3'b000;
  bit          d_rst = 1'b1;
  bit          d_bpen = 1'b0;
  bit [PW-1:0] d_bpaddr = '0;

  // Simple core model: what the monitor saw mid-cycle decides the PC advance.
  bit env_en = 1'b0;
  bit env_rst = 1'b0;

  // Reference model state.
  int        m_st = M_RESET;
  int        m_left = H;
  bit        m_skip = 1'b0;
  bit [31:0] m_cnt = '0;
  bit [2:0]  m_lvl = '0;
  bit [2:0]  m_press = '0;
  bit        m_en = 1'b0;
  bit        m_rst = 1'b0;
  bit [2:0]  raw_hist[$];
  bit [2:0]  samp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit r, u, s, hit, all_diff;
    bit [2:0] smp;
    if (reset) begin
      m_st = M_RESET; m_left = H; m_skip = 1'b0; m_cnt = '0;
      m_lvl = '0; m_press = '0;
      samp.delete();
      raw_hist.delete();
      raw_hist.push_back(3'b000);
      raw_hist.push_back(3'b000);
      return;
    end
    r = m_press[0];
    u = m_press[1] && !r;
    s = m_press[2] && !m_press[1] && !r;
    if (r || m_st == M_RESET) m_cnt = '0;
    else if (m_en && !m_rst && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    hit = (m_st == M_RUN) && !m_en;
    case (m_st)
      M_RESET: if (m_left == 1) m_st = M_HALT; else m_left--;
      M_HALT:  if (u) begin m_st = M_RUN; m_skip = 1'b0; end else if (s) m_st = M_STEP;
      M_RUN:   begin m_skip = 1'b0; if (u) m_st = M_HALT; else if (hit) m_st = M_BREAK; end
      M_STEP:  m_st = M_HALT;
      M_BREAK: if (u) begin m_st = M_RUN; m_skip = 1'b1; end else if (s) m_st = M_STEP;
      default: m_st = M_RESET;
    endcase
    if (r) begin m_st = M_RESET; m_left = H; end
    // Button level seen by the debouncer lags the pins by two edges.
    raw_hist.push_back(~btn_n);
    smp = raw_hist[0];
    void'(raw_hist.pop_front());
    samp.push_back(smp);
    if (samp.size() > D) void'(samp.pop_front());
    m_press = '0;
    for (int b = 0; b < 3; b++) begin
      all_diff = (samp.size() == D);
      foreach (samp[k]) if (samp[k][b] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[b]   = ~m_lvl[b];
        m_press[b] = m_lvl[b];
      end
    end
  endtask

  task automatic model_out();
    exp_t e;
    m_rst = (m_st == M_RESET);
    case (m_st)
      M_RESET: m_en = 1'b1;
      M_RUN:   m_en = !(bp_enable && pc == bp_addr && !m_skip);
      M_STEP:  m_en = 1'b1;
      default: m_en = 1'b0;
    endcase
    e.st = m_st; e.en = m_en; e.rst = m_rst; e.hit = (m_st == M_BREAK); e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (env_rst) pc = '0;
    else if (env_en) pc = pc + 1'b1;
    btn_n     = ~d_btn;
    reset     = d_rst;
    bp_enable = d_bpen;
    bp_addr   = d_bpaddr;
    #1;
    model_out();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      env_en  = cpu_en;
      env_rst = cpu_reset;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", {29'd0, state}, 32'(e.st));
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, e.en});
        chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, e.rst});
        chk("bp_hit", {31'd0, bp_hit}, {31'd0, e.hit});
        chk("instr_count", instr_count, e.cnt);
      end
    end
  end

  initial begin : stim
    int dur;
    int kind;
    // Block reset for one cycle, then let the hold sequence finish.
    d_rst = 1'b1; run_cycles(1);
    d_rst = 1'b0; run_cycles(10);
    // Long step press, then release.
    d_btn = 3'b100; run_cycles(40);
    d_btn = 3'b000; run_cycles(10);
    // Short run-button glitches never qualify.
    for (int g = 0; g < 5; g++) begin
      d_btn = 3'b010; run_cycles(3);
      d_btn = 3'b000; run_cycles(4);
    end
    // Breakpoint at 0x10 from a fresh PC.
    d_rst = 1'b1; run_cycles(1);
    d_rst = 1'b0; run_cycles(8);
    d_bpen = 1'b1; d_bpaddr = PW'(16);
    d_btn = 3'b010; run_cycles(8);
    d_btn = 3'b000; run_cycles(30);
    d_btn = 3'b010; run_cycles(8);
    d_btn = 3'b000; run_cycles(20);
    // Simultaneous run and reset presses while running.
    d_btn = 3'b011; run_cycles(8);
    d_btn = 3'b000; run_cycles(10);
    d_bpen = 1'b0;
    d_btn = 3'b010; run_cycles(8);
    d_btn = 3'b000; run_cycles(100);
    // Block reset while running.
    d_rst = 1'b1; run_cycles(1);
    d_rst = 1'b0; run_cycles(10);
    // Randomized segments.
    for (int seg = 0; seg < 400; seg++) begin
      kind = $urandom_range(0, 99);
      d_bpen   = ($urandom_range(0, 3) != 0);
      d_bpaddr = pc + PW'($urandom_range(0, 12));
      if (kind < 3) begin
        d_rst = 1'b1; run_cycles(1);
        d_rst = 1'b0;
      end else begin
        if (kind < 45)      d_btn = 3'b010;
        else if (kind < 75) d_btn = 3'b100;
        else if (kind < 80) d_btn = 3'b001;
        else                d_btn = 3'($urandom_range(0, 7));
        dur = $urandom_range(1, 10);
        run_cycles(dur);
        d_btn = 3'b000;
      end
      run_cycles($urandom_range(5, 25));
    end
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
